// File: rtl/c2h_pkg.sv
// Shared defaults and helpers for the C2H frame packing path.
package c2h_pkg;

    localparam int C2H_FRAME_W     = 4072;
    localparam int C2H_BEAT_W      = 512;
    localparam int C2H_IN_W        = 64;
    localparam int C2H_FRAME_CNT_W = 16;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/c2h_frame_buf.sv
// One frame buffer: word-indexed fill, truncated last word, zeroed whenever it
// is freed so an early-closed frame is padded with zeros.
module c2h_frame_buf
    import c2h_pkg::*;
#(
    parameter int FRAME_W = C2H_FRAME_W,
    parameter int IN_W    = C2H_IN_W,
    localparam int WORDS  = ceil_div(FRAME_W, IN_W),
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic               m_axis_c2h_aclk,
    input  logic               m_axis_c2h_aresetn,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [IN_W-1:0]    wr_data,
    input  logic               close,
    input  logic               free,
    output logic [FRAME_W-1:0] frame,
    output logic               full
);

    localparam int LAST_LO = (WORDS - 1) * IN_W;
    localparam int LAST_W  = FRAME_W - LAST_LO;

    always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
        if (!m_axis_c2h_aresetn) begin
            frame <= '0;
            full  <= 1'b0;
        end else if (clr || free) begin
            frame <= '0;
            full  <= 1'b0;
        end else begin
            if (wr_en && !full) begin
                for (int k = 0; k < WORDS - 1; k++) begin
                    if (wr_idx == IDX_W'(k))
                        frame[k*IN_W +: IN_W] <= wr_data;
                end
                // Only the bits that fit in the frame survive on the final word.
                if (wr_idx == IDX_W'(WORDS - 1))
                    frame[FRAME_W-1:LAST_LO] <= wr_data[LAST_W-1:0];
            end
            if (close)
                full <= 1'b1;
        end
    end

endmodule

// File: rtl/c2h_frame_packer.sv
// Packs a narrow word stream into FRAME_W-bit frames for the C2H writer,
// ping-ponging two buffers so one fills while the other is streamed out.
module c2h_frame_packer
    import c2h_pkg::*;
#(
    parameter int FRAME_W = C2H_FRAME_W,
    parameter int IN_W    = C2H_IN_W
) (
    input  logic                       m_axis_c2h_aclk,
    input  logic                       m_axis_c2h_aresetn,
    input  logic                       clr,
    input  logic [IN_W-1:0]            s_tdata,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic                       s_tlast,
    output logic [FRAME_W-1:0]         data,
    output logic                       data_valid,
    input  logic                       data_next,
    output logic [C2H_FRAME_CNT_W-1:0] frame_cnt,
    output logic                       short_frame
);

    localparam int WORDS = ceil_div(FRAME_W, IN_W);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Handshakes: a word moves when s_tvalid && s_tready on a clock edge; s_tvalid
    // may rise freely, s_tready never depends combinationally on s_tvalid. A frame
    // is consumed only when data_next arrives while data_valid is high.
    logic               wr_sel, rd_sel, wr_sel_n;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         full, full_n, wr_en, close_b, free_b;
    logic [FRAME_W-1:0] frame [2];
    logic               accept, close, consume;

    assign accept     = s_tvalid && s_tready;
    assign close      = accept && (s_tlast || idx == IDX_W'(WORDS - 1));
    assign data_valid = full[rd_sel];
    assign consume    = data_next && data_valid;
    assign data       = frame[rd_sel];

    always_comb begin
        wr_en    = '0;
        close_b  = '0;
        free_b   = '0;
        full_n   = '0;
        wr_sel_n = wr_sel ^ close;
        for (int i = 0; i < 2; i++) begin
            wr_en[i]   = accept && (wr_sel == 1'(i));
            close_b[i] = close && (wr_sel == 1'(i));
            free_b[i]  = consume && (rd_sel == 1'(i));
            full_n[i]  = (full[i] && !free_b[i]) || close_b[i];
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_buf
        c2h_frame_buf #(
            .FRAME_W (FRAME_W),
            .IN_W    (IN_W)
        ) u_buf (
            .m_axis_c2h_aclk    (m_axis_c2h_aclk),
            .m_axis_c2h_aresetn (m_axis_c2h_aresetn),
            .clr                (clr),
            .wr_en              (wr_en[g]),
            .wr_idx             (idx),
            .wr_data            (s_tdata),
            .close              (close_b[g]),
            .free               (free_b[g]),
            .frame              (frame[g]),
            .full               (full[g])
        );
    end

    always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
        if (!m_axis_c2h_aresetn) begin
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            idx         <= '0;
            s_tready    <= 1'b0;
            frame_cnt   <= '0;
            short_frame <= 1'b0;
        end else if (clr) begin
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            idx         <= '0;
            s_tready    <= 1'b0;
            frame_cnt   <= '0;
            short_frame <= 1'b0;
        end else begin
            wr_sel <= wr_sel_n;
            // Look at the post-edge state so a just-closed or just-freed buffer is seen.
            s_tready <= !full_n[wr_sel_n];
            if (accept)
                idx <= close ? '0 : idx + 1'b1;
            if (close && s_tlast && idx != IDX_W'(WORDS - 1))
                short_frame <= 1'b1;
            if (consume) begin
                rd_sel    <= ~rd_sel;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_c2h_frame_packer.sv
// Directed scoreboard bench for c2h_frame_packer.
module tb_c2h_frame_packer;
    import c2h_pkg::*;

    localparam int FW      = C2H_FRAME_W;
    localparam int IW      = C2H_IN_W;
    localparam int WORDS   = ceil_div(FW, IW);
    localparam int LAST_LO = (WORDS - 1) * IW;
    localparam int LAST_W  = FW - LAST_LO;

    logic          m_axis_c2h_aclk;
    logic          m_axis_c2h_aresetn;
    logic          clr;
    logic [IW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [FW-1:0] data;
    logic          data_valid;
    logic          data_next;
    logic [15:0]   frame_cnt;
    logic          short_frame;

    int            checks = 0;
    int            errors = 0;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] fa, fb, fx;
    logic [FW-1:0] held;
    logic          held_ok = 1'b0;

    c2h_frame_packer dut (
        .m_axis_c2h_aclk    (m_axis_c2h_aclk),
        .m_axis_c2h_aresetn (m_axis_c2h_aresetn),
        .clr                (clr),
        .s_tdata            (s_tdata),
        .s_tvalid           (s_tvalid),
        .s_tready           (s_tready),
        .s_tlast            (s_tlast),
        .data               (data),
        .data_valid         (data_valid),
        .data_next          (data_next),
        .frame_cnt          (frame_cnt),
        .short_frame        (short_frame)
    );

    // clock / reset
    initial m_axis_c2h_aclk = 1'b0;
    always #5 m_axis_c2h_aclk = ~m_axis_c2h_aclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        logic [IW-1:0] aw, ew;
        checks++;
        if (act !== exp) begin
            errors++;
            for (int k = 0; k < WORDS; k++) begin
                aw = IW'(act >> (k * IW));
                ew = IW'(exp >> (k * IW));
                if (aw !== ew) begin
                    $display("FAIL %s: word %0d got %h, expected %h", name, k, aw, ew);
                    break;
                end
            end
        end
    endtask

    function automatic logic [IW-1:0] word_of(input int seed, input int k);
        return IW'({32'(seed), 32'(k)});
    endfunction

    // Expected frame: word k at bits k*IW, last word truncated, rest zero.
    function automatic logic [FW-1:0] make_frame(input int seed, input int n);
        logic [FW-1:0] f = '0;
        logic [IW-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = word_of(seed, k);
            if (k == WORDS - 1) f[FW-1:LAST_LO] = w[LAST_W-1:0];
            else f[k*IW +: IW] = w;
        end
        return f;
    endfunction

    // driver tasks (called at posedge + 1)
    task automatic sync();
        @(posedge m_axis_c2h_aclk);
        #1;
    endtask

    task automatic send_word(input logic [IW-1:0] d, input logic last);
        int n = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        forever begin
            @(negedge m_axis_c2h_aclk);
            if (s_tready) begin
                @(posedge m_axis_c2h_aclk);
                #1;
                break;
            end
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL send_word_timeout: got s_tready=0 for %0d cycles, expected 1", n);
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int seed, input int n, input bit stall, output logic [FW-1:0] f);
        f = make_frame(seed, n);
        exp_q.push_back(f);
        for (int k = 0; k < n; k++) begin
            if (stall) begin
                repeat ($urandom_range(0, 3)) @(posedge m_axis_c2h_aclk);
                #1;
            end
            send_word(word_of(seed, k), (k == n - 1) && (n < WORDS));
        end
    endtask

    task automatic pulse_next();
        @(posedge m_axis_c2h_aclk);
        #1;
        data_next = 1'b1;
        @(posedge m_axis_c2h_aclk);
        #1;
        data_next = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        forever begin
            @(negedge m_axis_c2h_aclk);
            if (data_valid) break;
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL wait_valid_timeout: got data_valid=0, expected 1");
                break;
            end
        end
    endtask

    // scoreboard monitor: pops on each consumed frame, checks stability while held
    always @(negedge m_axis_c2h_aclk) begin
        if (!m_axis_c2h_aresetn || clr) begin
            held_ok = 1'b0;
        end else if (data_valid) begin
            if (held_ok) chk_frame("data_stable", data, held);
            held    = data;
            held_ok = 1'b1;
            if (data_next) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got frame, expected queue empty");
                end else begin
                    chk_frame("frame_data", data, exp_q.pop_front());
                end
                held_ok = 1'b0;
            end
        end else begin
            held_ok = 1'b0;
        end
    end

    initial begin
        m_axis_c2h_aresetn = 1'b0;
        clr       = 1'b0;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        data_next = 1'b0;

        // reset state
        repeat (2) @(negedge m_axis_c2h_aclk);
        chk("rst_data_valid", 64'(data_valid), 64'(0));
        chk("rst_s_tready", 64'(s_tready), 64'(0));
        chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        chk("rst_short_frame", 64'(short_frame), 64'(0));
        chk("rst_data_zero", 64'(|data), 64'(0));
        sync();
        m_axis_c2h_aresetn = 1'b1;
        @(negedge m_axis_c2h_aclk);
        chk("tready_first_cycle", 64'(s_tready), 64'(0));
        @(negedge m_axis_c2h_aclk);
        chk("tready_after_rst", 64'(s_tready), 64'(1));

        // 1: one full frame, word k = k
        sync();
        send_frame(0, WORDS, 1'b0, fa);
        @(negedge m_axis_c2h_aclk);
        chk("t1_valid", 64'(data_valid), 64'(1));
        chk("t1_word0", 64'(data[63:0]), 64'(0));
        chk("t1_word1", 64'(data[127:64]), 64'(1));
        chk("t1_last_trunc", 64'(data[4071:4032]), 64'(63));
        chk("t1_cnt_before", 64'(frame_cnt), 64'(0));
        pulse_next();
        @(negedge m_axis_c2h_aclk);
        chk("t1_cnt_after", 64'(frame_cnt), 64'(1));
        chk("t1_valid_drop", 64'(data_valid), 64'(0));

        // 2: two frames queued, then back-to-back hand-off
        sync();
        send_frame(1, WORDS, 1'b0, fa);
        send_frame(2, WORDS, 1'b0, fb);
        @(negedge m_axis_c2h_aclk);
        chk("t2_tready_full", 64'(s_tready), 64'(0));
        chk("t2_valid", 64'(data_valid), 64'(1));
        chk_frame("t2_frame_a", data, fa);
        pulse_next();
        @(negedge m_axis_c2h_aclk);
        chk("t2_no_gap", 64'(data_valid), 64'(1));
        chk_frame("t2_frame_b", data, fb);
        chk("t2_cnt", 64'(frame_cnt), 64'(2));
        @(negedge m_axis_c2h_aclk);
        chk("t2_tready_back", 64'(s_tready), 64'(1));
        pulse_next();
        @(negedge m_axis_c2h_aclk);
        chk("t2_cnt_end", 64'(frame_cnt), 64'(3));
        chk("t2_valid_end", 64'(data_valid), 64'(0));

        // 3: early close on word 9
        sync();
        send_frame(3, 10, 1'b0, fa);
        @(negedge m_axis_c2h_aclk);
        chk("t3_valid", 64'(data_valid), 64'(1));
        chk("t3_short", 64'(short_frame), 64'(1));
        chk("t3_pad_zero", 64'(|data[4071:640]), 64'(0));
        chk("t3_word9", 64'(data[639:576]), 64'h0000_0003_0000_0009);
        chk_frame("t3_frame", data, fa);
        pulse_next();
        @(negedge m_axis_c2h_aclk);
        chk("t3_short_sticky", 64'(short_frame), 64'(1));
        chk("t3_cnt", 64'(frame_cnt), 64'(4));

        // 4: close of B on the same edge that A is consumed
        sync();
        send_frame(4, WORDS, 1'b0, fa);
        fb = make_frame(5, WORDS);
        exp_q.push_back(fb);
        for (int k = 0; k < WORDS - 1; k++) send_word(word_of(5, k), 1'b0);
        data_next = 1'b1;
        send_word(word_of(5, WORDS - 1), 1'b0);
        data_next = 1'b0;
        @(negedge m_axis_c2h_aclk);
        chk("t4_valid", 64'(data_valid), 64'(1));
        chk_frame("t4_frame_b", data, fb);
        chk("t4_cnt", 64'(frame_cnt), 64'(5));
        pulse_next();
        @(negedge m_axis_c2h_aclk);
        chk("t4_cnt_end", 64'(frame_cnt), 64'(6));

        // 5: clr at word 30 with the other buffer full
        sync();
        send_frame(6, WORDS, 1'b0, fa);
        for (int k = 0; k < 30; k++) send_word(word_of(7, k), 1'b0);
        clr = 1'b1;
        exp_q.delete();
        sync();
        clr = 1'b0;
        @(negedge m_axis_c2h_aclk);
        chk("t5_valid", 64'(data_valid), 64'(0));
        chk("t5_tready_low", 64'(s_tready), 64'(0));
        chk("t5_cnt", 64'(frame_cnt), 64'(0));
        chk("t5_short", 64'(short_frame), 64'(0));
        chk("t5_data_zero", 64'(|data), 64'(0));
        @(negedge m_axis_c2h_aclk);
        chk("t5_tready_high", 64'(s_tready), 64'(1));
        sync();
        send_frame(8, WORDS, 1'b0, fa);
        @(negedge m_axis_c2h_aclk);
        chk_frame("t5_clean_frame", data, fa);
        pulse_next();
        // short frame lands in the buffer that held the discarded partial frame
        sync();
        send_frame(9, 5, 1'b0, fb);
        @(negedge m_axis_c2h_aclk);
        chk_frame("t5_no_residue", data, fb);
        pulse_next();
        @(negedge m_axis_c2h_aclk);
        chk("t5_cnt_end", 64'(frame_cnt), 64'(2));

        // 6: stalled stream over 3 frames, consumer one cycle after valid
        sync();
        clr = 1'b1;
        sync();
        clr = 1'b0;
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(10 + f, WORDS, 1'b1, fx);
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    wait_valid();
                    pulse_next();
                end
            end
        join
        @(negedge m_axis_c2h_aclk);
        chk("t6_cnt", 64'(frame_cnt), 64'(3));
        chk("t6_valid_end", 64'(data_valid), 64'(0));
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
